// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and decode constants for the multiplier issue
// scheduler (mul_issue_sched) and its writeback tracker (mul_sched_tracker).
//   state_e     : scheduler FSM states
//   trk_entry_t : one tracker slot {valid, rd}
//   is_mul_op() : MUL/MULH/MULHSU/MULHU decode from the relevant fields
package mul_sched_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } trk_entry_t;

  // funct3[2]=1 selects the divide group, which is not handled here.
  function automatic logic is_mul_op(input logic [6:0] opc,
                                     input logic [6:0] funct7,
                                     input logic       funct3_msb);
    return (opc == OPC_OP) && (funct7 == FUNCT7_MULDIV) && !funct3_msb;
  endfunction

endpackage

// File: rtl/mul_sched_tracker.sv
// mul_sched_tracker: MULT_STAGES-deep shift register of {valid, rd} that
// follows multiplies through the multiplier pipe, plus the RAW comparators.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   hold_i                   freeze the shift register
//   flush_i                  invalidate all entries (wins over hold)
//   issue_i, issue_rd_i      entry 0 load value
//   ra_idx_i, rb_idx_i       source registers checked for hazards
//   match_o                  some valid entry with rd!=0 matches ra or rb
//   busy_o                   any entry valid
//   empty_next_o             no entry valid after the coming edge
//   wb_valid_o, wb_rd_idx_o  last entry (rd forced 0 when invalid)
module mul_sched_tracker
  import mul_sched_pkg::*;
#(
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  input  logic       flush_i,
  input  logic       issue_i,
  input  logic [4:0] issue_rd_i,
  input  logic [4:0] ra_idx_i,
  input  logic [4:0] rb_idx_i,
  output logic       match_o,
  output logic       busy_o,
  output logic       empty_next_o,
  output logic       wb_valid_o,
  output logic [4:0] wb_rd_idx_o
);

  trk_entry_t [MULT_STAGES-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (flush_i) begin
      ent_d = '0;
    end else if (!hold_i) begin
      ent_d[0].valid = issue_i;
      ent_d[0].rd    = issue_i ? issue_rd_i : '0;
      for (int unsigned k = 1; k < MULT_STAGES; k++) begin
        ent_d[k] = ent_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  // The last entry participates: the regfile is written at the end of the
  // writeback cycle, so a reader in that same cycle would see the old value.
  always_comb begin
    match_o      = 1'b0;
    busy_o       = 1'b0;
    empty_next_o = 1'b1;
    for (int unsigned k = 0; k < MULT_STAGES; k++) begin
      if (ent_q[k].valid && (ent_q[k].rd != '0) &&
          ((ent_q[k].rd == ra_idx_i) || (ent_q[k].rd == rb_idx_i))) begin
        match_o = 1'b1;
      end
      if (ent_q[k].valid) busy_o = 1'b1;
      if (ent_d[k].valid) empty_next_o = 1'b0;
    end
  end

  assign wb_valid_o  = ent_q[MULT_STAGES-1].valid;
  assign wb_rd_idx_o = ent_q[MULT_STAGES-1].valid ? ent_q[MULT_STAGES-1].rd : '0;

endmodule

// File: rtl/mul_issue_sched.sv
// mul_issue_sched: issue scheduler and writeback tracker for the pipelined
// multiplier. Decodes the MUL group, raises RAW stalls against in-flight
// destinations, emits writeback valid/rd aligned with the multiplier result
// and offers a drain handshake (drain_req_i -> one-cycle drain_ack_o).
// Parameter MULT_STAGES: issue-to-result latency, 2 or 3.
// Ports: clk_i, rst_ni (async active-low); opcode_{valid,opcode,rd_idx,
//   ra_idx,rb_idx}_i issue slot; hold_i, flush_i, drain_req_i controls;
//   drain_ack_o, mul_issue_o, stall_o, busy_o, wb_valid_o, wb_rd_idx_o.
// Optional (macro MUL_SCHED_PERF_EN): perf_issue_cnt_o, perf_stall_cnt_o.
module mul_issue_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [4:0]  opcode_ra_idx_i,
  input  logic [4:0]  opcode_rb_idx_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        drain_req_i,
  output logic        drain_ack_o,
  output logic        mul_issue_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  state_e state_q, state_d;
  logic   is_mul, accepting, hz, match, empty_next;
  logic   unused_insn_bits;

  assign is_mul = is_mul_op(opcode_opcode_i[6:0], opcode_opcode_i[31:25],
                            opcode_opcode_i[14]);
  assign unused_insn_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[13:7]};

  mul_sched_tracker #(
    .MULT_STAGES (MULT_STAGES)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .issue_i      (mul_issue_o),
    .issue_rd_i   (opcode_rd_idx_i),
    .ra_idx_i     (opcode_ra_idx_i),
    .rb_idx_i     (opcode_rb_idx_i),
    .match_o      (match),
    .busy_o       (busy_o),
    .empty_next_o (empty_next),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_idx_o  (wb_rd_idx_o)
  );

  assign accepting = (state_q == IDLE) || (state_q == BUSY);
  assign hz        = opcode_valid_i && match;
  assign stall_o   = hz || (!accepting && is_mul && opcode_valid_i);
  // Gated by rst_ni so every output reads 0 while reset is asserted.
  assign mul_issue_o = rst_ni && opcode_valid_i && is_mul && !stall_o &&
                       !hold_i && !flush_i;
  assign drain_ack_o = (state_q == DONE);

  // empty_next already reflects flush and the current issue, so a drain
  // request that coincides with a flush acknowledges on the following cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!hold_i) begin
          if (drain_req_i)      state_d = empty_next ? DONE : DRAIN;
          else if (mul_issue_o) state_d = BUSY;
        end
      end
      BUSY: begin
        if (!hold_i) begin
          if (drain_req_i)     state_d = empty_next ? DONE : DRAIN;
          else if (empty_next) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (empty_next && (!hold_i || flush_i)) state_d = DONE;
      end
      // Leaves unconditionally so the ack stays a single-cycle pulse.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MUL_SCHED_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(mul_issue_o);
    stall_cnt_d = stall_cnt_q + 32'(stall_o && opcode_valid_i && !hold_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt_o = issue_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_issue_sched.sv
// Directed bench for mul_issue_sched: a MULT_STAGES=2 instance checked in
// full and a MULT_STAGES=3 instance on the same inputs for stall release.
module tb_mul_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [31:0] op_insn;
  logic [4:0]  op_rd, op_ra, op_rb;
  logic        hold, flush, drain_req;

  logic        drain_ack, mul_issue, stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic        stall3;
  logic        unused_ack3, unused_issue3, unused_busy3, unused_wbv3;
  logic [4:0]  unused_wbrd3;
`ifdef MUL_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_stall, unused_pi3, unused_ps3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_issue_sched #(.MULT_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_valid_i(op_valid), .opcode_opcode_i(op_insn),
    .opcode_rd_idx_i(op_rd), .opcode_ra_idx_i(op_ra), .opcode_rb_idx_i(op_rb),
    .hold_i(hold), .flush_i(flush), .drain_req_i(drain_req),
    .drain_ack_o(drain_ack), .mul_issue_o(mul_issue), .stall_o(stall),
    .busy_o(busy), .wb_valid_o(wb_valid), .wb_rd_idx_o(wb_rd)
`ifdef MUL_SCHED_PERF_EN
    , .perf_issue_cnt_o(perf_issue), .perf_stall_cnt_o(perf_stall)
`endif
  );

  mul_issue_sched #(.MULT_STAGES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_valid_i(op_valid), .opcode_opcode_i(op_insn),
    .opcode_rd_idx_i(op_rd), .opcode_ra_idx_i(op_ra), .opcode_rb_idx_i(op_rb),
    .hold_i(hold), .flush_i(flush), .drain_req_i(drain_req),
    .drain_ack_o(unused_ack3), .mul_issue_o(unused_issue3), .stall_o(stall3),
    .busy_o(unused_busy3), .wb_valid_o(unused_wbv3), .wb_rd_idx_o(unused_wbrd3)
`ifdef MUL_SCHED_PERF_EN
    , .perf_issue_cnt_o(unused_pi3), .perf_stall_cnt_o(unused_ps3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic drive(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    op_valid = 1'b1;
    op_insn  = rtype(f7, f3, rd, ra, rb);
    op_rd    = rd;
    op_ra    = ra;
    op_rb    = rb;
  endtask

  task automatic mul(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    drive(7'b0000001, 3'b000, rd, ra, rb);
  endtask

  task automatic nop();
    op_valid = 1'b0;
    op_insn  = '0;
    op_rd    = '0;
    op_ra    = '0;
    op_rb    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_issue"}, {31'b0, mul_issue}, 0);
    chk({tag, "_stall"}, {31'b0, stall}, 0);
    chk({tag, "_busy"},  {31'b0, busy}, 0);
    chk({tag, "_wbv"},   {31'b0, wb_valid}, 0);
    chk({tag, "_wbrd"},  {27'b0, wb_rd}, 0);
    chk({tag, "_ack"},   {31'b0, drain_ack}, 0);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; drain_req = 1'b0;
    nop();
    #2;
    chk_all_zero("rst");
    mul(5, 1, 2);
    #1 chk("rst_issue_gated", {31'b0, mul_issue}, 0);
    nop();
    #9 rst_n = 1'b1;                       // t=12, first live edge at 15

    // RAW stall against MUL x5 (2 and 3 stages)
    cyc(); mul(5, 1, 2); #1;
    chk("a0_issue", {31'b0, mul_issue}, 1); chk("a0_busy", {31'b0, busy}, 0);
    chk("a0_stall", {31'b0, stall}, 0);
    cyc(); drive(7'b0, 3'b000, 6, 5, 3); #1;
    chk("a1_stall", {31'b0, stall}, 1); chk("a1_stall3", {31'b0, stall3}, 1);
    chk("a1_busy", {31'b0, busy}, 1);   chk("a1_wbv", {31'b0, wb_valid}, 0);
    cyc(); #1;
    chk("a2_stall", {31'b0, stall}, 1); chk("a2_wbv", {31'b0, wb_valid}, 1);
    chk("a2_wbrd", {27'b0, wb_rd}, 5);
    cyc(); #1;
    chk("a3_stall", {31'b0, stall}, 0); chk("a3_stall3", {31'b0, stall3}, 1);
    chk("a3_busy", {31'b0, busy}, 0);   chk("a3_wbrd", {27'b0, wb_rd}, 0);
    cyc(); #1;
    chk("a4_stall3", {31'b0, stall3}, 0);
    cyc(); nop();

    // x0 destination never stalls but still writes back
    cyc(); mul(0, 1, 2); #1; chk("x0_issue", {31'b0, mul_issue}, 1);
    cyc(); drive(7'b0, 3'b000, 8, 0, 0); #1; chk("x0_stall", {31'b0, stall}, 0);
    cyc(); nop(); #1;
    chk("x0_wbv", {31'b0, wb_valid}, 1); chk("x0_wbrd", {27'b0, wb_rd}, 0);

    // back-to-back WAW on x7, DIV not decoded, MULHU decoded
    cyc(); mul(7, 1, 2); #1; chk("w0_issue", {31'b0, mul_issue}, 1);
    cyc(); mul(7, 3, 4); #1; chk("w1_issue", {31'b0, mul_issue}, 1);
    cyc(); drive(7'b0000001, 3'b100, 11, 1, 2); #1;
    chk("div_issue", {31'b0, mul_issue}, 0); chk("div_stall", {31'b0, stall}, 0);
    chk("w2_wbv", {31'b0, wb_valid}, 1);     chk("w2_wbrd", {27'b0, wb_rd}, 7);
    cyc(); drive(7'b0000001, 3'b011, 10, 3, 4); #1;
    chk("mulhu_issue", {31'b0, mul_issue}, 1);
    chk("w3_wbv", {31'b0, wb_valid}, 1);     chk("w3_wbrd", {27'b0, wb_rd}, 7);
    cyc(); nop(); #1; chk("w4_wbv", {31'b0, wb_valid}, 0);
    cyc(); #1; chk("mulhu_wbrd", {27'b0, wb_rd}, 10);
    cyc();

    // hold for three cycles delays writeback by three
    cyc(); mul(5, 1, 2); #1; chk("h0_issue", {31'b0, mul_issue}, 1);
    cyc(); nop(); hold = 1'b1; #1; chk("h1_wbv", {31'b0, wb_valid}, 0);
    cyc(); mul(9, 3, 4); #1;
    chk("h2_issue", {31'b0, mul_issue}, 0); chk("h2_wbv", {31'b0, wb_valid}, 0);
    cyc(); nop(); #1; chk("h3_wbv", {31'b0, wb_valid}, 0);
    cyc(); hold = 1'b0; #1;
    chk("h4_wbv", {31'b0, wb_valid}, 0); chk("h4_busy", {31'b0, busy}, 1);
    cyc(); #1;
    chk("h5_wbv", {31'b0, wb_valid}, 1); chk("h5_wbrd", {27'b0, wb_rd}, 5);
    cyc(); #1; chk("h6_busy", {31'b0, busy}, 0);

    // flush under hold kills the in-flight multiply
    cyc(); mul(5, 1, 2); #1; chk("f0_issue", {31'b0, mul_issue}, 1);
    cyc(); nop(); hold = 1'b1; flush = 1'b1; #1; chk("f1_busy", {31'b0, busy}, 1);
    cyc(); hold = 1'b0; flush = 1'b0; #1;
    chk("f2_busy", {31'b0, busy}, 0); chk("f2_wbv", {31'b0, wb_valid}, 0);
    cyc(); #1; chk("f3_wbv", {31'b0, wb_valid}, 0);

    // drain with two multiplies in flight
    cyc(); mul(5, 1, 2); #1; chk("d0_issue", {31'b0, mul_issue}, 1);
    cyc(); mul(6, 1, 2); #1; chk("d1_issue", {31'b0, mul_issue}, 1);
    cyc(); nop(); drain_req = 1'b1; #1;
    chk("d2_wbrd", {27'b0, wb_rd}, 5); chk("d2_ack", {31'b0, drain_ack}, 0);
    cyc(); mul(9, 1, 2); #1;
    chk("d3_stall", {31'b0, stall}, 1); chk("d3_issue", {31'b0, mul_issue}, 0);
    chk("d3_wbrd", {27'b0, wb_rd}, 6);  chk("d3_ack", {31'b0, drain_ack}, 0);
    cyc(); #1;
    chk("d4_ack", {31'b0, drain_ack}, 1); chk("d4_stall", {31'b0, stall}, 1);
    chk("d4_busy", {31'b0, busy}, 0);
    cyc(); drain_req = 1'b0; #1;
    chk("d5_ack", {31'b0, drain_ack}, 0); chk("d5_issue", {31'b0, mul_issue}, 1);
    cyc(); nop();
    cyc(); #1; chk("d7_wbrd", {27'b0, wb_rd}, 9);
    cyc();

    // drain from IDLE, held high to get a second ack
    cyc(); drain_req = 1'b1; #1; chk("i0_ack", {31'b0, drain_ack}, 0);
    cyc(); #1; chk("i1_ack", {31'b0, drain_ack}, 1);
    cyc(); #1; chk("i2_ack", {31'b0, drain_ack}, 0);
    cyc(); drain_req = 1'b0; #1; chk("i3_ack", {31'b0, drain_ack}, 1);
    cyc(); #1; chk("i4_ack", {31'b0, drain_ack}, 0);

    // flush together with drain request
    cyc(); mul(5, 1, 2); #1; chk("fd0_issue", {31'b0, mul_issue}, 1);
    cyc(); nop(); flush = 1'b1; drain_req = 1'b1; #1;
    chk("fd1_ack", {31'b0, drain_ack}, 0);
    cyc(); flush = 1'b0; drain_req = 1'b0; #1;
    chk("fd2_ack", {31'b0, drain_ack}, 1); chk("fd2_busy", {31'b0, busy}, 0);
    cyc(); #1; chk("fd3_ack", {31'b0, drain_ack}, 0);

    // asynchronous reset mid-flight
    cyc(); mul(5, 1, 2); #1; chk("r0_issue", {31'b0, mul_issue}, 1);
    cyc(); nop(); #1; chk("r1_busy", {31'b0, busy}, 1);
    cyc(); #1; chk("r2_wbv", {31'b0, wb_valid}, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("arst");
    #3 rst_n = 1'b1;
    cyc(); #1;
    chk("pr0_wbv", {31'b0, wb_valid}, 0); chk("pr0_busy", {31'b0, busy}, 0);
    cyc(); #1; chk("pr1_wbv", {31'b0, wb_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
